// File: rtl/vga_pkg.sv
// Shared constants for the VGA scan-out path.
// Default 640x480@60 timing, image geometry and stage bundles.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int VGA_HS_START = VGA_H_ACTIVE + VGA_H_FP;
    localparam int VGA_HS_END   = VGA_HS_START + VGA_H_SYNC;
    localparam int VGA_VS_START = VGA_V_ACTIVE + VGA_V_FP;
    localparam int VGA_VS_END   = VGA_VS_START + VGA_V_SYNC;

    localparam int VGA_ADDR_W = 19;
    localparam int VGA_IMG_W  = 200;
    localparam int VGA_IMG_H  = 200;
    localparam int VGA_SCALE  = 2;

    // Wide enough for both 800-pixel lines and 525-line frames
    localparam int CNT_W = 10;

    typedef struct packed {
        logic hs;
        logic vs;
        logic blank_n;
        logic win;
    } sync_t;

endpackage

// File: rtl/vga_timing.sv
// Pixel-rate strobe, raster counters and raw sync/blank generation.
// Everything here describes the current counter position, undelayed.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input  logic             clk,
    input  logic             reset,
    output logic             pix_en,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             hs,
    output logic             vs,
    output logic             blank_n,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic phase;

    assign pix_en = phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase <= 1'b0;
            hc    <= '0;
            vc    <= '0;
        end else begin
            phase <= ~phase;
            if (phase) begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == V_LAST) ? '0 : vc + 1'b1;
                end else begin
                    hc <= hc + 1'b1;
                end
            end
        end
    end

    assign hs          = !(hc >= HS_START && hc < HS_END);
    assign vs          = !(vc >= VS_START && vc < VS_END);
    assign blank_n     = (hc < H_ACT) && (vc < V_ACT);
    assign frame_start = pix_en && (hc == '0) && (vc == '0);

endmodule

// File: rtl/display_scanout.sv
// VGA scan-out: image-window address generation with integer upscaling
// and a two-stage pipeline that keeps syncs aligned with memory data.
module display_scanout
    import vga_pkg::*;
#(
    parameter int                H_ACTIVE = VGA_H_ACTIVE,
    parameter int                H_FP     = VGA_H_FP,
    parameter int                H_SYNC   = VGA_H_SYNC,
    parameter int                H_BP     = VGA_H_BP,
    parameter int                V_ACTIVE = VGA_V_ACTIVE,
    parameter int                V_FP     = VGA_V_FP,
    parameter int                V_SYNC   = VGA_V_SYNC,
    parameter int                V_BP     = VGA_V_BP,
    parameter int                IMG_W    = VGA_IMG_W,
    parameter int                IMG_H    = VGA_IMG_H,
    parameter int                SCALE    = VGA_SCALE,
    parameter int                ADDR_W   = VGA_ADDR_W,
    parameter logic [ADDR_W-1:0] IMG_BASE = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              pixel_rd_en,
    input  logic [7:0]        pixel,
    output logic              vga_clk,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic [7:0]        vga_r,
    output logic [7:0]        vga_g,
    output logic [7:0]        vga_b,
    output logic              frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int SUB_W   = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [CNT_W-1:0]  H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  WIN_HC   = CNT_W'(IMG_W * SCALE);
    localparam logic [CNT_W-1:0]  WIN_VC   = CNT_W'(IMG_H * SCALE);
    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);

    logic             pix_en;
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic             hs_raw;
    logic             vs_raw;
    logic             blank_raw;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .pix_en      (pix_en),
        .hc          (hc),
        .vc          (vc),
        .hs          (hs_raw),
        .vs          (vs_raw),
        .blank_n     (blank_raw),
        .frame_start (frame_start)
    );

    assign vga_clk = pix_en;

    logic              in_win;
    logic [ADDR_W-1:0] col;
    logic [ADDR_W-1:0] row_base;
    logic [SUB_W-1:0]  hsub;
    logic [SUB_W-1:0]  vsub;

    assign in_win = (hc < WIN_HC) && (vc < WIN_VC);

    // Incremental address walk: each stored pixel repeats SCALE times per axis
    always_ff @(posedge clk) begin
        if (reset) begin
            col      <= '0;
            hsub     <= '0;
            row_base <= IMG_BASE;
            vsub     <= '0;
        end else if (pix_en) begin
            if (hc == H_LAST) begin
                col  <= '0;
                hsub <= '0;
                if (vc == V_LAST) begin
                    row_base <= IMG_BASE;
                    vsub     <= '0;
                end else if (vsub == SUB_LAST) begin
                    vsub     <= '0;
                    row_base <= row_base + ROW_STEP;
                end else begin
                    vsub <= vsub + 1'b1;
                end
            end else if (in_win) begin
                if (hsub == SUB_LAST) begin
                    hsub <= '0;
                    col  <= col + 1'b1;
                end else begin
                    hsub <= hsub + 1'b1;
                end
            end
        end
    end

    sync_t s1;

    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_addr  <= IMG_BASE;
            pixel_rd_en <= 1'b0;
            s1          <= '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, win: 1'b0};
        end else if (pix_en) begin
            pixel_rd_en <= in_win;
            if (in_win) begin
                pixel_addr <= row_base + col;
            end
            s1 <= '{hs: hs_raw, vs: vs_raw, blank_n: blank_raw, win: in_win};
        end
    end

    // Memory data lands between the two pix_en edges, so stage 2 sees it
    always_ff @(posedge clk) begin
        if (reset) begin
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
            vga_r       <= 8'h00;
            vga_g       <= 8'h00;
            vga_b       <= 8'h00;
        end else if (pix_en) begin
            vga_hs      <= s1.hs;
            vga_vs      <= s1.vs;
            vga_blank_n <= s1.blank_n;
            vga_r       <= s1.win ? pixel : 8'h00;
            vga_g       <= s1.win ? pixel : 8'h00;
            vga_b       <= s1.win ? pixel : 8'h00;
        end
    end

endmodule

// File: tb/tb_display_scanout.sv
// Directed bench for display_scanout with a shortened vertical frame
// (27 lines, 8-row image) so a whole frame fits in a short run.
module tb_display_scanout;

    localparam int AW      = 19;
    localparam int HT      = 800;
    localparam int VT      = 27;
    localparam int WIN_W   = 400;
    localparam int WIN_H   = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] pixel_addr;
    logic          pixel_rd_en;
    logic [7:0]    pixel = 8'h00;
    logic          vga_clk;
    logic          vga_hs;
    logic          vga_vs;
    logic          vga_blank_n;
    logic [7:0]    vga_r;
    logic [7:0]    vga_g;
    logic [7:0]    vga_b;
    logic          frame_start;

    always #5 clk = ~clk;

    always @(posedge clk) pixel <= pixel_addr[7:0];

    display_scanout #(
        .V_ACTIVE (20),
        .V_FP     (2),
        .V_SYNC   (2),
        .V_BP     (3),
        .IMG_H    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_addr  (pixel_addr),
        .pixel_rd_en (pixel_rd_en),
        .pixel       (pixel),
        .vga_clk     (vga_clk),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    typedef struct {
        int            e;
        logic [AW-1:0] addr;
        logic          rd;
        logic          blank;
        logic          hs;
        logic          vs;
        logic [7:0]    rgb;
        logic          vclk;
        logic          fs;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passed = 0;
    int   edges = 0;
    bit   mon_on = 1'b0;
    int   mon_err = 0;
    int   blank_cnt = 0;
    logic prev_hs = 1'b1;
    logic prev_vs = 1'b1;
    logic prev_blank = 1'b0;
    int   fs_q[$];
    int   hs_fall[$];
    int   hs_rise[$];
    int   vs_fall[$];
    int   vs_rise[$];
    int   blank_rise[$];

    function automatic logic win_at(int n);
        int h = n % HT;
        int v = (n / HT) % VT;
        return (h < WIN_W) && (v < WIN_H);
    endfunction

    function automatic logic [AW-1:0] addr_at(int n);
        int h = n % HT;
        int v = (n / HT) % VT;
        return AW'((v / 2) * 200 + h / 2);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d want %0d", name, act, exp);
    endtask

    task automatic add(int e, int addr, logic rd, logic blank, logic hs,
                       logic vs, int rgb, logic vclk, logic fs);
        vec_t v;
        v.e = e;
        v.addr = AW'(addr);
        v.rd = rd;
        v.blank = blank;
        v.hs = hs;
        v.vs = vs;
        v.rgb = 8'(rgb);
        v.vclk = vclk;
        v.fs = fs;
        vecs.push_back(v);
    endtask

    task automatic check_vec(string tag, vec_t v);
        check({tag, "_addr"}, 32'(pixel_addr), 32'(v.addr));
        check({tag, "_rd"}, 32'(pixel_rd_en), 32'(v.rd));
        check({tag, "_blank"}, 32'(vga_blank_n), 32'(v.blank));
        check({tag, "_hs"}, 32'(vga_hs), 32'(v.hs));
        check({tag, "_vs"}, 32'(vga_vs), 32'(v.vs));
        check({tag, "_rgb"}, {8'h0, vga_r, vga_g, vga_b},
              {8'h0, v.rgb, v.rgb, v.rgb});
        check({tag, "_vclk"}, 32'(vga_clk), 32'(v.vclk));
        check({tag, "_fs"}, 32'(frame_start), 32'(v.fs));
    endtask

    task automatic tick();
        int n;
        logic [7:0] exp;
        @(negedge clk);
        edges++;
        if (mon_on) begin
            if (frame_start) fs_q.push_back(edges);
            if (prev_hs && !vga_hs) hs_fall.push_back(edges);
            if (!prev_hs && vga_hs) hs_rise.push_back(edges);
            if (prev_vs && !vga_vs) vs_fall.push_back(edges);
            if (!prev_vs && vga_vs) vs_rise.push_back(edges);
            if (!prev_blank && vga_blank_n) blank_rise.push_back(edges);
            if (vga_blank_n && edges < 1604) blank_cnt++;
            prev_hs = vga_hs;
            prev_vs = vga_vs;
            prev_blank = vga_blank_n;
            if (edges >= 2) begin
                n = (edges - 2) / 2;
                if (pixel_rd_en !== win_at(n)) mon_err++;
                else if (win_at(n) && pixel_addr !== addr_at(n)) mon_err++;
            end
            if (edges >= 4) begin
                n = (edges - 4) / 2;
                exp = win_at(n) ? addr_at(n)[7:0] : 8'h00;
                if (vga_r !== exp || vga_g !== exp || vga_b !== exp) mon_err++;
            end
        end
    endtask

    vec_t rst_v;

    initial begin
        rst_v = '{e: 0, addr: '0, rd: 0, blank: 0, hs: 1, vs: 1,
                  rgb: 8'h00, vclk: 0, fs: 0};

        add(0,     0,    0, 0, 1, 1, 8'h00, 0, 0);
        add(1,     0,    0, 0, 1, 1, 8'h00, 1, 1);
        add(2,     0,    1, 0, 1, 1, 8'h00, 0, 0);
        add(3,     0,    1, 0, 1, 1, 8'h00, 1, 0);
        add(4,     0,    1, 1, 1, 1, 8'h00, 0, 0);
        add(6,     1,    1, 1, 1, 1, 8'h00, 0, 0);
        add(8,     1,    1, 1, 1, 1, 8'h01, 0, 0);
        add(9,     1,    1, 1, 1, 1, 8'h01, 1, 0);
        add(800,   199,  1, 1, 1, 1, 8'hC7, 0, 0);
        add(802,   199,  0, 1, 1, 1, 8'hC7, 0, 0);
        add(804,   199,  0, 1, 1, 1, 8'h00, 0, 0);
        add(1282,  199,  0, 1, 1, 1, 8'h00, 0, 0);
        add(1284,  199,  0, 0, 1, 1, 8'h00, 0, 0);
        add(1314,  199,  0, 0, 1, 1, 8'h00, 0, 0);
        add(1316,  199,  0, 0, 0, 1, 8'h00, 0, 0);
        add(1506,  199,  0, 0, 0, 1, 8'h00, 0, 0);
        add(1508,  199,  0, 0, 1, 1, 8'h00, 0, 0);
        add(1602,  0,    1, 0, 1, 1, 8'h00, 0, 0);
        add(1606,  1,    1, 1, 1, 1, 8'h00, 0, 0);
        add(3200,  199,  0, 0, 1, 1, 8'h00, 0, 0);
        add(3202,  200,  1, 0, 1, 1, 8'h00, 0, 0);
        add(3204,  200,  1, 1, 1, 1, 8'hC8, 0, 0);
        add(3206,  201,  1, 1, 1, 1, 8'hC8, 0, 0);
        add(24800, 1599, 1, 1, 1, 1, 8'h3F, 0, 0);
        add(25602, 1599, 0, 0, 1, 1, 8'h00, 0, 0);
        add(25604, 1599, 0, 1, 1, 1, 8'h00, 0, 0);
        add(35202, 1599, 0, 0, 1, 1, 8'h00, 0, 0);
        add(35204, 1599, 0, 0, 1, 0, 8'h00, 0, 0);
        add(38402, 1599, 0, 0, 1, 0, 8'h00, 0, 0);
        add(38404, 1599, 0, 0, 1, 1, 8'h00, 0, 0);
        add(43201, 1599, 0, 0, 1, 1, 8'h00, 1, 1);
        add(43202, 0,    1, 0, 1, 1, 8'h00, 0, 0);
        add(43206, 1,    1, 1, 1, 1, 8'h00, 0, 0);

        // Reset held for three clocks, checked while still asserted
        repeat (3) @(negedge clk);
        check_vec("in_reset", rst_v);

        reset = 1'b0;
        edges = 0;
        mon_on = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            while (edges < vecs[i].e) tick();
            check_vec($sformatf("v%0d_e%0d", i, vecs[i].e), vecs[i]);
        end

        check("fs_period", fs_q.size() >= 2 ? fs_q[1] - fs_q[0] : -1, 43200);
        check("hs_period", hs_fall.size() >= 2 ? hs_fall[1] - hs_fall[0] : -1, 1600);
        check("hs_low", (hs_fall.size() >= 1 && hs_rise.size() >= 1)
              ? hs_rise[0] - hs_fall[0] : -1, 192);
        check("vs_low", (vs_fall.size() >= 1 && vs_rise.size() >= 1)
              ? vs_rise[0] - vs_fall[0] : -1, 3200);
        check("blank_rise1", blank_rise.size() >= 2 ? blank_rise[1] : -1, 1604);
        check("blank_line0", blank_cnt, 1280);
        check("scan_model", mon_err, 0);

        // Second frame: stop at vc=10, hc=123 while pix_en is high
        while (edges < 59447) tick();
        check("pre_rst_addr", 32'(pixel_addr), 1061);
        check("pre_rst_rd", 32'(pixel_rd_en), 1);
        check("pre_rst_win_model", mon_err, 0);
        reset = 1'b1;
        mon_on = 1'b0;
        tick();
        check_vec("mid_reset", rst_v);
        tick();
        tick();
        reset = 1'b0;
        edges = 0;
        tick();
        check("rr_vclk", 32'(vga_clk), 1);
        check("rr_fs", 32'(frame_start), 1);
        tick();
        check("rr_addr0", 32'(pixel_addr), 0);
        check("rr_rd0", 32'(pixel_rd_en), 1);
        tick();
        tick();
        check("rr_addr1", 32'(pixel_addr), 0);
        tick();
        tick();
        check("rr_addr2", 32'(pixel_addr), 1);
        check("rr_rgb0", 32'(vga_r), 0);
        check("rr_blank", 32'(vga_blank_n), 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/display_scanout.md
# display_scanout

Display scan-out stage downstream of the pipeline's memory stage. It generates 640x480@60 VGA timing from the 50 MHz system clock and issues read addresses into the image region of data memory. It converts the returned 8-bit grayscale pixel into VGA RGB, upscaling the stored image by an integer factor. Its memory read port sits beside the pipeline's memory stage on the data memory.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths in lines
- IMG_W / IMG_H, 200 / 200, stored image size in pixels
- SCALE, 2, replication factor per axis; requires IMG_W*SCALE ≤ H_ACTIVE and IMG_H*SCALE ≤ V_ACTIVE
- IMG_BASE, 19'h0, memory address of image pixel (0,0)
- ADDR_W, 19, memory address width

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-high
- pixel_addr  out  ADDR_W  image read address
- pixel_rd_en  out  1  read request; high only inside the image window
- pixel  in  8  read data; valid one clk after pixel_addr changes
- vga_clk  out  1  pixel-rate strobe (pix_en)
- vga_hs / vga_vs  out  1 each  syncs, active-low
- vga_blank_n  out  1  high during the active 640x480 area
- vga_r / vga_g / vga_b  out  8 each  colour
- frame_start  out  1  one-clk pulse at pixel (0,0)

## Operation
- pix_en: a phase bit that toggles every clk; pix_en = phase. Phase resets to 0, so the first pix_en is the 2nd clk after reset release.
- Counters hc 0..799 and vc 0..524 advance only on pix_en.
  - hc 799→0 increments vc; vc 524→0 wraps the frame.
  - frame_start = pix_en && hc==0 && vc==0.
- Sync generation:
  - hs low for hc in [656,752).
  - vs low for vc in [490,492).
  - blank_n = hc<640 && vc<480.
- Image window: hc < IMG_W*SCALE and vc < IMG_H*SCALE.
- Address generation is incremental; no multiplier.
  - col counter and hsub (0..SCALE-1) step across the line. row_base and vsub step down the frame.
  - Inside the window, address = row_base + col.
  - At the end of each line, vsub increments. On the wrap of vsub from SCALE-1, row_base += IMG_W.
  - At frame wrap, row_base = IMG_BASE and vsub = 0.
- Outside the window: pixel_rd_en = 0 and pixel_addr holds its last value.
- Colour: r = g = b = pixel when the delayed in-window flag is 1, else 0. This includes blanking and the active area outside the window.
- Reset values:
  - hc = vc = 0, phase = 0.
  - pixel_addr = IMG_BASE, pixel_rd_en = 0.
  - hs = vs = 1, blank_n = 0.
  - rgb = 0, frame_start = 0.
- Reset mid-frame: the next clk shows all reset values. Scan restarts at (0,0) with row_base = IMG_BASE.

## Timing
- Stage 0: counters hold position P.
- Stage 1: pixel_addr, pixel_rd_en, and delayed hs/vs/blank_n/in-window flag are registered on the next pix_en.
- Memory: returns pixel one clk later, which is before the following pix_en.
- Stage 2: vga_r/g/b/hs/vs/blank_n are registered on that pix_en.
- Total latency from counter position P to VGA outputs is 2 pixel periods (4 clk). Syncs and colour stay exactly aligned.
- frame_start is not delayed; it marks the counter position.
- pixel_addr changes at most once per 2 clk.

## Structure
- vga_pkg holds:
  - the 640x480 timing constants and derived totals H_TOTAL = 800 and V_TOTAL = 525;
  - sync start/end constants;
  - ADDR_W and the default image geometry.
- Sub-module vga_timing contains phase/pix_en, hc/vc, the raw hs/vs/blank_n and frame_start.
- display_scanout contains the window/address logic and the two-stage output pipeline.

## Test plan
- Reset: hold reset 3 clk.
  - During and after reset: hs = vs = 1, blank_n = 0, rgb = 0, pixel_addr = IMG_BASE, rd_en = 0.
  - After release: first vga_clk high on the 2nd clk, and frame_start on that same clk.
- Line timing:
  - 800 pix_en between hs falling edges.
  - hs low for 96 pix_en.
  - blank_n high for 640 pix_en per line, starting 2 pixel periods after hc = 0.
- Frame timing:
  - vs low for 2 lines (vc 490–491).
  - frame_start period = 420000 pix_en = 840000 clk.
- Scaling, with a memory model returning addr[7:0] at 1-clk latency and IMG_BASE = 0:
  - line 0 addresses are 0,0,1,1,…,199,199; line 1 repeats them; line 2 starts at 200;
  - last in-window address is 39999;
  - vga_r at the first active output = 0x00 and at the 3rd = 0x01.
- Outside window: at hc = 400–639 and at vc ≥ 400, rd_en = 0 and rgb = 0 while blank_n = 1.
- Mid-frame reset: assert reset at vc = 300, hc = 123.
  - Next clk shows reset values.
  - After release, the first addresses are 0,0,1 and frame_start fires.
